// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding and next-PC sequencing for the 3-stage F -> DE -> MW pipe.
// Holds the pipe on slow data-memory accesses, times them out, and sequences irq entry and redirects.
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] de_rs1,
    input  logic [4:0] de_rs2,
    input  logic [4:0] mw_waddr,
    input  logic       mw_regwr,
    input  logic       mw_is_mem,
    input  logic       dmem_ack,
    input  logic       branch_taken,
    input  logic       mret_de,
    input  logic       irq_pending,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       stall_fd,
    output logic       stall_mw,
    output logic       flush_de,
    output logic       flush_mw,
    output logic [1:0] pc_sel,
    output logic       irq_take,
    output logic       mem_fault
);
    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_MEM_WAIT  = 2'd1,
        S_IRQ_ENTER = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;
    logic       w_mem_busy;
    logic       w_mw_writes;

    assign w_mem_busy  = mw_is_mem & ~dmem_ack;
    assign w_mw_writes = mw_regwr & (mw_waddr != 5'd0) & ~rst;
    assign fwd_a       = w_mw_writes & (mw_waddr == de_rs1);
    assign fwd_b       = w_mw_writes & (mw_waddr == de_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        stall_fd        = 1'b0;
        stall_mw        = 1'b0;
        flush_de        = 1'b0;
        flush_mw        = 1'b0;
        pc_sel          = 2'b00;
        irq_take        = 1'b0;
        mem_fault       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_busy) begin
                        stall_fd        = 1'b1;
                        stall_mw        = 1'b1;
                        w_state_next    = S_MEM_WAIT;
                        w_wait_cnt_next = 8'd1;
                    end else if (irq_pending) begin
                        irq_take     = 1'b1;
                        pc_sel       = 2'b10;
                        flush_de     = 1'b1;
                        w_state_next = S_IRQ_ENTER;
                    end else if (mret_de) begin
                        pc_sel   = 2'b11;
                        flush_de = 1'b1;
                    end else if (branch_taken) begin
                        pc_sel   = 2'b01;
                        flush_de = 1'b1;
                    end
                end
                // Redirects and irqs stay parked in DE until the access resolves.
                S_MEM_WAIT: begin
                    if (dmem_ack) begin
                        w_state_next    = S_RUN;
                        w_wait_cnt_next = 8'd0;
                    end else if (r_wait_cnt == LIMIT) begin
                        mem_fault       = 1'b1;
                        flush_mw        = 1'b1;
                        w_state_next    = S_RUN;
                        w_wait_cnt_next = 8'd0;
                    end else begin
                        stall_fd        = 1'b1;
                        stall_mw        = 1'b1;
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    end
                end
                S_IRQ_ENTER: begin
                    flush_de     = 1'b1;
                    w_state_next = S_RUN;
                    if (w_mem_busy) begin
                        stall_fd        = 1'b1;
                        stall_mw        = 1'b1;
                        w_state_next    = S_MEM_WAIT;
                        w_wait_cnt_next = 8'd1;
                    end
                end
                default: begin
                    w_state_next    = S_RUN;
                    w_wait_cnt_next = 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all checked against
// an expectation model built from the pipeline rules (waiting/elapsed-cycle bookkeeping).
module tb_pipe_hazard_ctrl;
    localparam int WL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] de_rs1, de_rs2, mw_waddr;
    logic       mw_regwr, mw_is_mem, dmem_ack, branch_taken, mret_de, irq_pending;
    logic       fwd_a, fwd_b, stall_fd, stall_mw, flush_de, flush_mw, irq_take, mem_fault;
    logic [1:0] pc_sel;

    pipe_hazard_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .de_rs1(de_rs1), .de_rs2(de_rs2), .mw_waddr(mw_waddr),
        .mw_regwr(mw_regwr), .mw_is_mem(mw_is_mem), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken), .mret_de(mret_de), .irq_pending(irq_pending),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_fd(stall_fd), .stall_mw(stall_mw),
        .flush_de(flush_de), .flush_mw(flush_mw), .pc_sel(pc_sel),
        .irq_take(irq_take), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int step_no = 0;

    // Expectation model: is an access outstanding, how long has it waited, did we just take an irq.
    bit waiting_on_mem = 0;
    int cycles_waited = 0;
    bit just_took_irq = 0;
    logic prev_irq_take = 1'b0;

    task automatic step(input string tag, input bit r, input int rs1, input int rs2,
                        input int wa, input bit rw, input bit im, input bit ack,
                        input bit br, input bit mr, input bit irq);
        logic [10:0] got, want;
        bit e_fa, e_fb, e_stall, e_fde, e_fmw, e_take, e_fault;
        int e_pc;
        bit n_wait, n_irq;
        int n_cnt;
        bit busy;
        @(negedge clk);
        rst = r; de_rs1 = 5'(rs1); de_rs2 = 5'(rs2); mw_waddr = 5'(wa);
        mw_regwr = rw; mw_is_mem = im; dmem_ack = ack;
        branch_taken = br; mret_de = mr; irq_pending = irq;
        #1;
        busy = im && !ack;
        e_fa = !r && rw && wa != 0 && wa == rs1;
        e_fb = !r && rw && wa != 0 && wa == rs2;
        e_stall = 0; e_fde = 0; e_fmw = 0; e_take = 0; e_fault = 0; e_pc = 0;
        n_wait = 0; n_cnt = 0; n_irq = 0;
        if (r) begin
            // everything quiet, model returns to idle
        end else if (waiting_on_mem) begin
            if (ack) begin
                // access completes: nothing held
            end else if (cycles_waited == WL) begin
                e_fault = 1; e_fmw = 1;
            end else begin
                e_stall = 1; n_wait = 1; n_cnt = cycles_waited + 1;
            end
        end else begin
            if (just_took_irq) e_fde = 1;
            if (busy) begin
                e_stall = 1; n_wait = 1; n_cnt = 1;
            end else if (!just_took_irq) begin
                if (irq) begin
                    e_take = 1; e_pc = 2; e_fde = 1; n_irq = 1;
                end else if (mr) begin
                    e_pc = 3; e_fde = 1;
                end else if (br) begin
                    e_pc = 1; e_fde = 1;
                end
            end
        end
        want = {e_fa, e_fb, e_stall, e_stall, e_fde, e_fmw, 2'(e_pc), e_take, e_fault, 1'b0};
        got  = {fwd_a, fwd_b, stall_fd, stall_mw, flush_de, flush_mw, pc_sel, irq_take, mem_fault, 1'b0};
        step_no++;
        total_cnt++;
        assert (got === want) pass_cnt++;
        else $error("FAIL %s step %0d: outputs fa,fb,sfd,smw,fde,fmw,pc,take,fault = %b, expected %b",
                    tag, step_no, got[10:1], want[10:1]);
        total_cnt++;
        assert (!(irq_take === 1'b1 && prev_irq_take === 1'b1)) pass_cnt++;
        else $error("FAIL %s step %0d: irq_take high two cycles running, got %b after %b, expected not both 1",
                    tag, step_no, irq_take, prev_irq_take);
        $display("step %0d %-10s rst=%0d out=%b exp=%b", step_no, tag, r, got[10:1], want[10:1]);
        prev_irq_take = irq_take;
        @(posedge clk);
        waiting_on_mem = n_wait;
        cycles_waited = n_cnt;
        just_took_irq = n_irq;
    endtask

    initial begin
        rst = 1'b1; de_rs1 = 0; de_rs2 = 0; mw_waddr = 0; mw_regwr = 0; mw_is_mem = 0;
        dmem_ack = 0; branch_taken = 0; mret_de = 0; irq_pending = 0;
        // Reset holds all outputs low even with hazards present on the inputs.
        step("reset", 1, 5, 5, 5, 1, 1, 0, 1, 1, 1);
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Forwarding: x5 hits both operands, x0 never forwards.
        step("fwd_x5", 0, 5, 5, 5, 1, 0, 0, 0, 0, 0);
        step("fwd_x0", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("fwd_nowr", 0, 7, 7, 7, 0, 0, 0, 0, 0, 0);
        // Load acked on the third cycle.
        step("load_c1", 0, 1, 2, 3, 1, 1, 0, 0, 0, 0);
        step("load_c2", 0, 1, 2, 3, 1, 1, 0, 0, 0, 0);
        step("load_ack", 0, 1, 2, 3, 1, 1, 1, 0, 0, 0);
        step("idle", 0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        // Ack in the first access cycle costs nothing.
        step("ack_fast", 0, 1, 2, 3, 1, 1, 1, 0, 0, 0);
        // Timeout with no ack.
        for (int i = 0; i < WL + 1; i++) step("timeout", 0, 4, 6, 9, 1, 1, 0, 0, 0, 0);
        step("after_to", 0, 4, 6, 9, 0, 0, 0, 0, 0, 0);
        // irq beats a branch in the same cycle; next cycle kills the wrong-path fetch.
        step("irq_br", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("irq_ent", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mret", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("branch", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // irq arriving during a memory wait is deferred until after the ack.
        step("wirq_c1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        step("wirq_c2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        step("wirq_ack", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        step("wirq_take", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("irq_busy", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("irq_busy2", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        // Reset two cycles into a wait: no fault afterwards.
        step("rwait_c1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("rwait_c2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("rwait_rst", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < WL + 1; i++) step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Random traffic, biased towards long memory waits and register-number collisions.
        for (int i = 0; i < 400; i++) begin
            bit im_r, ack_r;
            im_r  = ($urandom_range(0, 99) < 45);
            ack_r = ($urandom_range(0, 99) < 25);
            step("random", ($urandom_range(0, 99) < 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), im_r, ack_r, ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15));
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
